// File: rtl/inst_mem_banked.sv
// inst_mem_banked: banked, run-time loadable instruction memory.
// NB program images of 2**IW words x DW bits. Fetch reads are registered
// (1-cycle latency); a streaming loader writes one image at a time.
// Optional feature macro: INST_MEM_PARITY_EN (one even-parity bit per word,
// rechecked on fetch and reported on ParityErr).
//
// Loader handshake: a word is accepted in any cycle where LoadReady=1 and
// LoadValid=1. LoadReady depends only on the FSM state, never on LoadValid,
// so the source may hold LoadValid high while LoadReady is low without effect.
module inst_mem_banked #(
   parameter int IW = 10,
   parameter int DW = 9,
   parameter int NB = 4
) (
   input  logic                  Clk,
   input  logic                  Reset,
   input  logic [$clog2(NB)-1:0] ProgSel,
   input  logic                  FetchReq,
   input  logic [IW-1:0]         InstAddress,
   output logic [DW-1:0]         InstOut,
   output logic                  InstValid,
   output logic                  FetchBusy,
   input  logic                  LoadStart,
   input  logic [$clog2(NB)-1:0] LoadBank,
   input  logic [DW-1:0]         LoadData,
   input  logic                  LoadValid,
   input  logic                  LoadLast,
   output logic                  LoadReady,
   output logic                  LoadDone,
   output logic                  LoadErr,
   output logic                  ParityErr
);

   localparam int BW    = $clog2(NB);
   localparam int DEPTH = 2 ** IW;
   localparam logic [IW-1:0] PTR_MAX = '1;

   typedef enum logic {IDLE, LOAD} state_t;

   state_t        state;
   logic [BW-1:0] bank;
   logic [IW-1:0] ptr;
   logic          fetch_ok;
   logic          wr_en;

   logic [DW-1:0] mem [NB][DEPTH];
`ifdef INST_MEM_PARITY_EN
   logic          par_mem [NB][DEPTH];
`endif

   // Fetches are only served in IDLE; a write never lands during a Reset cycle
   // so an aborted load keeps exactly the words accepted before the reset.
   assign fetch_ok  = FetchReq && (state == IDLE);
   assign wr_en     = (state == LOAD) && LoadValid && !Reset;
   assign LoadReady = (state == LOAD);
   assign FetchBusy = (state == LOAD);

   // Loader FSM: latch target bank, walk the write pointer, flag overflow.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state    <= IDLE;
         bank     <= '0;
         ptr      <= '0;
         LoadDone <= 1'b0;
         LoadErr  <= 1'b0;
      end else begin
         LoadDone <= 1'b0;
         case (state)
            IDLE: begin
               if (LoadStart) begin
                  bank    <= LoadBank;
                  ptr     <= '0;
                  LoadErr <= 1'b0;
                  state   <= LOAD;
               end
            end
            LOAD: begin
               if (LoadValid) begin
                  if (LoadLast) begin
                     LoadDone <= 1'b1;
                     state    <= IDLE;
                  end else if (ptr == PTR_MAX) begin
                     // Bank full without a last marker: stop, never wrap.
                     LoadErr  <= 1'b1;
                     LoadDone <= 1'b1;
                     state    <= IDLE;
                  end else begin
                     ptr <= ptr + IW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Storage write port: only the latched bank is ever written; no reset.
   always_ff @(posedge Clk) begin
      if (wr_en) begin
         mem[bank][ptr] <= LoadData;
`ifdef INST_MEM_PARITY_EN
         par_mem[bank][ptr] <= ^LoadData;
`endif
      end
   end

   // Registered fetch port: InstOut holds when no fetch is accepted.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         InstOut   <= '0;
         InstValid <= 1'b0;
`ifdef INST_MEM_PARITY_EN
         ParityErr <= 1'b0;
`endif
      end else begin
         InstValid <= fetch_ok;
         if (fetch_ok) begin
            InstOut <= mem[ProgSel][InstAddress];
         end
`ifdef INST_MEM_PARITY_EN
         // Never-written words are all-zero with a zero parity bit: clean.
         ParityErr <= fetch_ok &&
                      ((^mem[ProgSel][InstAddress]) != par_mem[ProgSel][InstAddress]);
`endif
      end
   end

`ifndef INST_MEM_PARITY_EN
   assign ParityErr = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_banked.sv
// tb_inst_mem_banked: directed bench for inst_mem_banked (IW=10, DW=9, NB=4).
module tb_inst_mem_banked;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [1:0] ProgSel = '0;
   logic       FetchReq = 1'b0;
   logic [9:0] InstAddress = '0;
   logic [8:0] InstOut;
   logic       InstValid;
   logic       FetchBusy;
   logic       LoadStart = 1'b0;
   logic [1:0] LoadBank = '0;
   logic [8:0] LoadData = '0;
   logic       LoadValid = 1'b0;
   logic       LoadLast = 1'b0;
   logic       LoadReady;
   logic       LoadDone;
   logic       LoadErr;
   logic       ParityErr;

   int total = 0;
   int bad   = 0;

   inst_mem_banked #(.IW(10), .DW(9), .NB(4)) dut (
      .Clk(Clk), .Reset(Reset), .ProgSel(ProgSel), .FetchReq(FetchReq),
      .InstAddress(InstAddress), .InstOut(InstOut), .InstValid(InstValid),
      .FetchBusy(FetchBusy), .LoadStart(LoadStart), .LoadBank(LoadBank),
      .LoadData(LoadData), .LoadValid(LoadValid), .LoadLast(LoadLast),
      .LoadReady(LoadReady), .LoadDone(LoadDone), .LoadErr(LoadErr),
      .ParityErr(ParityErr)
   );

   // clock
   always #5 Clk = ~Clk;

   // advance one cycle; outputs are sampled 1ns after the rising edge
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      tick();
      tick();
      total++; if ({InstValid, FetchBusy, LoadReady, LoadDone, LoadErr, ParityErr} !== 6'b0) begin bad++; $display("FAIL reset_flags: got %b want 000000", {InstValid, FetchBusy, LoadReady, LoadDone, LoadErr, ParityErr}); end
      total++; if (InstOut !== 9'h000) begin bad++; $display("FAIL reset_instout: got %h want 000", InstOut); end
      Reset = 1'b0;
      ProgSel = 2'd0; InstAddress = 10'd5; FetchReq = 1'b1;
      tick();
      FetchReq = 1'b0;
      total++; if (InstValid !== 1'b1) begin bad++; $display("FAIL first_fetch_valid: got %b want 1", InstValid); end
      total++; if (InstOut !== 9'h000) begin bad++; $display("FAIL first_fetch_data: got %h want 000", InstOut); end
      total++; if ({FetchBusy, LoadReady, LoadDone, LoadErr, ParityErr} !== 5'b0) begin bad++; $display("FAIL first_fetch_flags: got %b want 00000", {FetchBusy, LoadReady, LoadDone, LoadErr, ParityErr}); end
      tick();
      total++; if (InstValid !== 1'b0) begin bad++; $display("FAIL idle_valid: got %b want 0", InstValid); end
   endtask

   task automatic test_load();
      logic [8:0] w [3];
      logic [8:0] exp_rd [4];
      int ready_cnt;
      w = '{9'h101, 9'h0AA, 9'h1FF};
      exp_rd = '{9'h101, 9'h0AA, 9'h1FF, 9'h000};
      ready_cnt = 0;
      LoadStart = 1'b1; LoadBank = 2'd2;
      tick();
      LoadStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         LoadValid = 1'b1; LoadData = w[i]; LoadLast = (i == 2);
         if (LoadReady === 1'b1) ready_cnt++;
         tick();
      end
      LoadValid = 1'b0; LoadLast = 1'b0;
      total++; if (ready_cnt != 3) begin bad++; $display("FAIL load_ready_cycles: got %0d want 3", ready_cnt); end
      total++; if ({LoadDone, FetchBusy, LoadReady} !== 3'b100) begin bad++; $display("FAIL load_done_cycle: got done/busy/ready=%b want 100", {LoadDone, FetchBusy, LoadReady}); end
      // fetch issued in the LoadDone cycle, then back-to-back
      FetchReq = 1'b1; ProgSel = 2'd2;
      for (int a = 0; a < 4; a++) begin
         if (a == 3) begin ProgSel = 2'd1; InstAddress = 10'd0; end
         else InstAddress = 10'(a);
         tick();
         if (a == 0) begin
            total++; if (LoadDone !== 1'b0) begin bad++; $display("FAIL load_done_pulse: got %b want 0", LoadDone); end
         end
         total++; if (InstValid !== 1'b1 || InstOut !== exp_rd[a]) begin bad++; $display("FAIL load_readback_%0d: got v=%b d=%h want v=1 d=%h", a, InstValid, InstOut, exp_rd[a]); end
      end
      FetchReq = 1'b0;
      tick();
      total++; if (InstValid !== 1'b0 || InstOut !== 9'h000) begin bad++; $display("FAIL hold_after_fetch: got v=%b d=%h want v=0 d=000", InstValid, InstOut); end
   endtask

   task automatic test_fetch_during_load();
      // LoadStart and FetchReq together in IDLE
      FetchReq = 1'b1; ProgSel = 2'd2; InstAddress = 10'd2;
      LoadStart = 1'b1; LoadBank = 2'd3;
      tick();
      LoadStart = 1'b0;
      total++; if (InstValid !== 1'b1 || InstOut !== 9'h1FF || LoadReady !== 1'b1) begin bad++; $display("FAIL start_with_fetch: got v=%b d=%h rdy=%b want v=1 d=1ff rdy=1", InstValid, InstOut, LoadReady); end
      // fetch refused while loading
      InstAddress = 10'd0;
      tick();
      FetchReq = 1'b0;
      total++; if (InstValid !== 1'b0 || InstOut !== 9'h1FF || FetchBusy !== 1'b1) begin bad++; $display("FAIL refused_fetch: got v=%b d=%h busy=%b want v=0 d=1ff busy=1", InstValid, InstOut, FetchBusy); end
      // LoadStart in LOAD must not retarget the load
      LoadStart = 1'b1; LoadBank = 2'd0;
      LoadValid = 1'b1; LoadData = 9'h055; LoadLast = 1'b1;
      tick();
      LoadStart = 1'b0; LoadValid = 1'b0; LoadLast = 1'b0;
      total++; if (LoadDone !== 1'b1) begin bad++; $display("FAIL single_word_done: got %b want 1", LoadDone); end
      FetchReq = 1'b1; ProgSel = 2'd3; InstAddress = 10'd0;
      tick();
      total++; if (InstOut !== 9'h055) begin bad++; $display("FAIL bank3_word: got %h want 055", InstOut); end
      ProgSel = 2'd0;
      tick();
      FetchReq = 1'b0;
      total++; if (InstOut !== 9'h000) begin bad++; $display("FAIL bank0_untouched: got %h want 000", InstOut); end
   endtask

   task automatic test_overflow();
      int acc;
      acc = 0;
      LoadStart = 1'b1; LoadBank = 2'd1;
      tick();
      LoadStart = 1'b0;
      for (int i = 0; i < 1027; i++) begin
         LoadValid = 1'b1; LoadData = 9'(i * 3 + 1);
         if (i == 1024) begin
            total++; if (LoadReady !== 1'b0) begin bad++; $display("FAIL excess_ready: got %b want 0", LoadReady); end
         end
         if (LoadReady === 1'b1) acc++;
         tick();
         if (i == 1023) begin
            total++; if (LoadDone !== 1'b1 || LoadErr !== 1'b1) begin bad++; $display("FAIL overflow_flags: got done=%b err=%b want 1 1", LoadDone, LoadErr); end
         end
      end
      LoadValid = 1'b0;
      total++; if (acc != 1024) begin bad++; $display("FAIL overflow_accepted: got %0d want 1024", acc); end
      total++; if (LoadErr !== 1'b1 || LoadDone !== 1'b0 || FetchBusy !== 1'b0) begin bad++; $display("FAIL overflow_after: got err=%b done=%b busy=%b want 1 0 0", LoadErr, LoadDone, FetchBusy); end
      FetchReq = 1'b1; ProgSel = 2'd1; InstAddress = 10'd0;
      tick();
      total++; if (InstOut !== 9'h001) begin bad++; $display("FAIL overflow_addr0: got %h want 001", InstOut); end
      InstAddress = 10'd1;
      tick();
      total++; if (InstOut !== 9'h004) begin bad++; $display("FAIL overflow_addr1: got %h want 004", InstOut); end
      InstAddress = 10'd1023;
      tick();
      total++; if (InstOut !== 9'h1FE) begin bad++; $display("FAIL overflow_addr1023: got %h want 1fe", InstOut); end
      ProgSel = 2'd2; InstAddress = 10'd0;
      tick();
      FetchReq = 1'b0;
      total++; if (InstOut !== 9'h101) begin bad++; $display("FAIL overflow_other_bank: got %h want 101", InstOut); end
   endtask

   task automatic test_reset_mid_load();
      logic [8:0] exp_rd [4];
      exp_rd = '{9'h011, 9'h022, 9'h1FF, 9'h000};
      LoadStart = 1'b1; LoadBank = 2'd2;
      tick();
      LoadStart = 1'b0;
      total++; if (LoadErr !== 1'b0) begin bad++; $display("FAIL err_cleared_by_start: got %b want 0", LoadErr); end
      LoadValid = 1'b1; LoadData = 9'h011;
      tick();
      LoadData = 9'h022;
      tick();
      Reset = 1'b1; LoadData = 9'h033;
      tick();
      Reset = 1'b0; LoadValid = 1'b0;
      total++; if ({LoadReady, FetchBusy, LoadDone, LoadErr, InstValid} !== 5'b0) begin bad++; $display("FAIL mid_reset_flags: got %b want 00000", {LoadReady, FetchBusy, LoadDone, LoadErr, InstValid}); end
      tick();
      total++; if (LoadDone !== 1'b0) begin bad++; $display("FAIL mid_reset_no_done: got %b want 0", LoadDone); end
      FetchReq = 1'b1; ProgSel = 2'd2;
      for (int a = 0; a < 4; a++) begin
         InstAddress = 10'(a);
         tick();
         total++; if (InstValid !== 1'b1 || InstOut !== exp_rd[a]) begin bad++; $display("FAIL mid_reset_readback_%0d: got v=%b d=%h want v=1 d=%h", a, InstValid, InstOut, exp_rd[a]); end
      end
      FetchReq = 1'b0;
      tick();
   endtask

   task automatic test_parity();
      logic [8:0] bank0_word;
`ifdef INST_MEM_PARITY_EN
      bank0_word = dut.mem[0][7];
      bank0_word[0] = ~bank0_word[0];
      dut.mem[0][7] = bank0_word;
      FetchReq = 1'b1; ProgSel = 2'd0; InstAddress = 10'd7;
      tick();
      total++; if (ParityErr !== 1'b1 || InstValid !== 1'b1) begin bad++; $display("FAIL parity_flip: got perr=%b v=%b want 1 1", ParityErr, InstValid); end
      InstAddress = 10'd6;
      tick();
      total++; if (ParityErr !== 1'b0) begin bad++; $display("FAIL parity_clean: got %b want 0", ParityErr); end
      FetchReq = 1'b0;
      tick();
      total++; if (ParityErr !== 1'b0) begin bad++; $display("FAIL parity_no_fetch: got %b want 0", ParityErr); end
`else
      bank0_word = 9'h000;
      FetchReq = 1'b1; ProgSel = 2'd2; InstAddress = 10'd2;
      tick();
      FetchReq = 1'b0;
      total++; if (ParityErr !== 1'b0 || InstOut !== 9'h1FF || InstOut === bank0_word) begin bad++; $display("FAIL parity_tied_low: got perr=%b d=%h want 0 1ff", ParityErr, InstOut); end
`endif
   endtask

   initial begin
      test_reset();
      test_load();
      test_fetch_during_load();
      test_overflow();
      test_reset_mid_load();
      test_parity();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/inst_mem_banked.md
# inst_mem_banked

Banked, run-time loadable instruction memory for the core's fetch stage. It holds NB independent program images of 2**IW words each, DW bits per word. A select input picks which image is fetched, and fetch reads are registered. A streaming loader port writes a program image into any bank after reset, so a new program does not require re-elaboration.

## Interface
- IW, 10: address width; each bank holds 2**IW words.
- DW, 9: instruction word width.
- NB, 4: number of banks (program images), >= 2.
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- ProgSel  in  $clog2(NB)  bank used for fetch, sampled with FetchReq.
- FetchReq  in  1  fetch request.
- InstAddress  in  IW  fetch address (program counter).
- InstOut  out  DW  fetched instruction, registered.
- InstValid  out  1  InstOut updated this cycle.
- FetchBusy  out  1  loader active; fetches are refused.
- LoadStart  in  1  begin loading bank LoadBank from address 0.
- LoadBank  in  $clog2(NB)  target bank, sampled with LoadStart.
- LoadData  in  DW  word to write.
- LoadValid  in  1  LoadData valid.
- LoadLast  in  1  final word of image, qualified by LoadValid.
- LoadReady  out  1  loader accepts a word this cycle.
- LoadDone  out  1  one-cycle pulse: load finished.
- LoadErr  out  1  sticky: image overflowed bank; cleared by the next LoadStart or Reset.
- ParityErr  out  1  parity mismatch on the current InstOut (see Configuration).

## Operation
- FSM states IDLE and LOAD. Reset forces IDLE.
- IDLE:
  - FetchReq=1 reads mem[ProgSel][InstAddress].
  - LoadStart=1 latches LoadBank, clears the write pointer and LoadErr, and moves to LOAD.
  - LoadStart and FetchReq in the same IDLE cycle: the fetch is served and the load starts next cycle.
- LOAD:
  - LoadReady=1 and FetchBusy=1.
  - Each cycle with LoadValid=1 writes LoadData to mem[bank][ptr], then ptr increments.
  - LoadValid=1 with LoadLast=1 writes the word, pulses LoadDone next cycle and returns to IDLE.
  - Overflow: a word accepted at ptr=2**IW-1 without LoadLast is written, then sets LoadErr, pulses LoadDone and returns to IDLE. The pointer never wraps.
  - LoadStart while in LOAD is ignored.
  - FetchReq in LOAD is refused: InstValid=0 the next cycle and InstOut holds.
- Writes go only to the latched bank. Other banks are untouched.
- Memory contents are not cleared by Reset. A Reset mid-load aborts the load, keeps the words already written, and sets no LoadDone or LoadErr.

## Timing
- Fetch latency is 1 cycle: request in cycle N gives InstOut/InstValid valid in cycle N+1. Back-to-back requests give one word per cycle.
- InstValid=0 in any cycle following no accepted request. InstOut holds its last value.
- Load throughput is one word per cycle while LoadValid=1. LoadReady is combinational on state only.
- LoadDone is high for exactly one cycle, the cycle after the last accepted word. FetchBusy falls in that same cycle, so a fetch can be requested then.
- A fetch of a word written in cycle N, issued in cycle N+1 or later, returns the new data.
- Reset values: InstOut=0, InstValid=0, FetchBusy=0, LoadReady=0, LoadDone=0, LoadErr=0, ParityErr=0.

## Configuration
- Macro INST_MEM_PARITY_EN.
- Defined:
  - Each stored word carries one extra even-parity bit, computed on every loader write.
  - On fetch, parity is rechecked, and ParityErr is registered alongside InstOut with the same latency. It is 0 when InstValid=0.
  - Words never written (initial zero) are treated as parity-correct.
- Undefined: no parity storage, and ParityErr is tied to 0. The port is always present.

## Test plan
- Reset, then FetchReq with InstAddress=5 -> next cycle InstValid=1, InstOut=0; all other outputs 0.
- Load bank 2 with words 9'h101, 9'h0AA, 9'h1FF (LoadLast on the third) -> LoadReady high for 3 cycles, LoadDone pulse once. A fetch with ProgSel=2 at addresses 0..2 returns those words back-to-back; ProgSel=1 at address 0 returns 0.
- FetchReq during LOAD -> InstValid=0, FetchBusy=1, InstOut unchanged. LoadStart and FetchReq together in IDLE -> fetch data next cycle and LoadReady high the same cycle.
- Stream 2**IW+3 words without LoadLast -> all 2**IW written, LoadErr=1, LoadDone pulse, return to IDLE. The excess words are not accepted (LoadReady=0) and the bank's address 0 keeps the first word.
- Reset asserted after 2 of 4 words -> IDLE and no LoadDone. The 2 written words read back; addresses 2..3 keep their old contents.
- With INST_MEM_PARITY_EN, force-flip one stored bit of bank 0 address 7 -> fetch of address 7 gives ParityErr=1 with InstValid=1; address 6 gives ParityErr=0.
